// File: rtl/reqack_stream_responder.sv
// Responder side of the req/ack pull handshake: a small FIFO fed by a
// valid/ready stream, serving one word per single-cycle ack pulse.
module reqack_stream_responder #(
   parameter int                    data_width    = 32,
   parameter int                    depth         = 4,
   parameter logic [data_width-1:0] initial_value = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [data_width-1:0]      s_data,
   input  logic                       req,
   output logic                       ack,
   output logic [data_width-1:0]      dout,
   output logic [31:0]                count,
   output logic [$clog2(depth):0]     level
);

   localparam int AW = $clog2(depth);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(depth);

   logic [data_width-1:0] mem_q [depth];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  ack_q, ack_d;
   logic [data_width-1:0] dout_q, dout_d;
   logic [31:0]           count_q, count_d;

   logic                  push;
   logic                  pop;

   // Both handshakes are decided purely from registered state, so there is
   // no combinational path from req to ack/dout nor from s_data to dout.
   always_comb begin
      push = s_valid && (level_q != FULL_LEVEL);
      pop  = req && !ack_q && (level_q != '0);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ack_d    = 1'b0;
      dout_d   = dout_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (pop) begin
         ack_d    = 1'b1;
         dout_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + AW'(1);
         count_d  = count_q + 32'd1;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ack_q    <= 1'b0;
         dout_q   <= initial_value;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ack_q    <= ack_d;
         dout_q   <= dout_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   always_comb begin
      s_ready = (level_q != FULL_LEVEL);
      ack     = ack_q;
      dout    = dout_q;
      count   = count_q;
      level   = level_q;
   end

endmodule
